// File: rtl/cntr8_sched.sv
// cntr8_sched: round-robin command scheduler driving the load/inc pins of an 8-bit counter.
module cntr8_sched (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [1:0] req0_op,
  input  logic [1:0] req1_op,
  input  logic [7:0] req0_arg,
  input  logic [7:0] req1_arg,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic       abort,
  output logic       cnt_load,
  output logic       cnt_inc,
  output logic [7:0] cnt_d_in,
  input  logic [7:0] cnt_d_out,
  output logic       done_valid,
  output logic       done_id,
  output logic       done_err,
  output logic [7:0] done_val,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, DONE = 2'b11} state_t;
  state_t     state, state_d;
  logic       ptr, id_q, err_q, err_d, accept, sel;
  logic [1:0] op_q, op_in;
  logic [7:0] arg_q, arg_in, rem;
  always_comb begin
    req0_ready = state == IDLE && req0_valid && (!req1_valid || !ptr);
    req1_ready = state == IDLE && req1_valid && (!req0_valid || ptr);
    accept     = req0_ready || req1_ready;
    sel        = req1_ready;
    op_in      = sel ? req1_op : req0_op;
    arg_in     = sel ? req1_arg : req0_arg;
    state_d    = state;
    err_d      = err_q;
    case (state)
      IDLE: if (accept) begin
        state_d = op_in == 2'b00 ? LOAD : (op_in == 2'b11 || arg_in == 8'd0) ? DONE : RUN;
        err_d   = op_in == 2'b11;
      end
      LOAD: begin
        state_d = DONE;
        err_d   = abort;
      end
      RUN: begin
        state_d = (abort || rem == 8'd1) ? DONE : RUN;
        err_d   = abort;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      id_q  <= 1'b0;
      err_q <= 1'b0;
      op_q  <= 2'b00;
      arg_q <= 8'd0;
      rem   <= 8'd0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      if (accept) begin
        ptr   <= !sel;
        id_q  <= sel;
        op_q  <= op_in;
        arg_q <= arg_in;
        rem   <= arg_in;
      end else if (state == RUN) begin
        rem <= rem - 8'd1;
      end
    end
  end
  // Outside RUN the counter reloads itself (or arg_q in LOAD), so it never free-runs.
  always_comb begin
    cnt_load   = state != RUN;
    cnt_inc    = state == RUN && op_q == 2'b01;
    cnt_d_in   = state == LOAD ? arg_q : cnt_d_out;
    done_valid = state == DONE;
    done_id    = done_valid && id_q;
    done_err   = done_valid && err_q;
    done_val   = cnt_d_out;
    o_state    = state;
  end
endmodule

// File: tb/tb_cntr8_sched.sv
// tb_cntr8_sched: randomized bench with a stub counter and a per-command transaction model.
module tb_cntr8_sched;
  logic       clk = 0, reset_n = 0;
  logic       req0_valid = 0, req1_valid = 0, abort = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic [7:0] req0_arg = 0, req1_arg = 0;
  logic       req0_ready, req1_ready, cnt_load, cnt_inc, done_valid, done_id, done_err;
  logic [7:0] cnt_d_in, cnt_d_out, done_val;
  logic [1:0] o_state;
  int n_cmp = 0, n_bad = 0;
  int cur = 0, ptr = 0;

  cntr8_sched dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_arg(req0_arg), .req1_arg(req1_arg),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .abort(abort),
    .cnt_load(cnt_load), .cnt_inc(cnt_inc), .cnt_d_in(cnt_d_in), .cnt_d_out(cnt_d_out),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err), .done_val(done_val),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_d_out <= 8'h00;
    else cnt_d_out <= cnt_load ? cnt_d_in : (cnt_inc ? cnt_d_out + 8'd1 : cnt_d_out - 8'd1);

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input bit v0, input bit v1, input logic [1:0] o0, input logic [7:0] a0,
                         input logic [1:0] o1, input logic [7:0] a1, input int ab);
    int w, op, arg, lat, steps, exp_steps, err, val;
    bit seen;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_op = o0; req0_arg = a0; req1_op = o1; req1_arg = a1;
    #1;
    w = (v0 && v1) ? ptr : (v1 ? 1 : 0);
    chk("ready0", req0_ready, v0 && w == 0);
    chk("ready1", req1_ready, v1 && w == 1);
    if (!(v0 || v1)) begin
      chk("idle_frozen", cnt_d_out, cur);
      return;
    end
    op  = w ? o1 : o0;
    arg = w ? a1 : a0;
    ptr = 1 - w;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    if (op == 0) begin
      lat = 1; exp_steps = 0; err = (ab == 1); val = arg;
    end else if (op == 3 || arg == 0) begin
      lat = 0; exp_steps = 0; err = (op == 3); val = cur;
    end else begin
      exp_steps = (ab >= 1 && ab <= arg) ? ab : arg;
      err = (ab >= 1 && ab <= arg);
      lat = exp_steps;
      val = (op == 1) ? (cur + exp_steps) & 255 : (cur - exp_steps) & 255;
    end
    steps = 0; seen = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      abort = (c == ab);
      if (c == 1 && op == 0) begin
        chk("load_pin", cnt_load, 1);
        chk("load_d_in", cnt_d_in, arg);
      end
      if (!cnt_load) begin
        steps++;
        chk("step_dir", cnt_inc, op == 1);
      end
      if (done_valid) begin
        seen = 1;
        chk("done_latency", c, lat + 1);
      end
    end
    abort = 0;
    if (!seen) chk("done_timeout", 0, 1);
    chk("steps", steps, exp_steps);
    chk("done_id", done_id, w);
    chk("done_err", done_err, err);
    chk("done_val", done_val, val);
    cur = val;
    @(negedge clk);
    chk("back_idle", o_state, 0);
    chk("frozen", cnt_d_out, cur);
  endtask

  initial begin
    #1;
    chk("rst_state", o_state, 0);
    chk("rst_load", cnt_load, 1);
    chk("rst_inc", cnt_inc, 0);
    chk("rst_done", done_valid, 0);
    @(negedge clk); reset_n = 1;
    run_cmd(1, 0, 2'b00, 8'h10, 2'b00, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_20", cnt_d_out, 8'h10);
    end
    run_cmd(0, 1, 2'b00, 8'h00, 2'b01, 8'd5, 0);
    for (int i = 0; i < 4; i++) run_cmd(1, 1, 2'b10, 8'd1, 2'b10, 8'd1, 0);
    run_cmd(1, 0, 2'b01, 8'd0, 2'b00, 8'h00, 0);
    run_cmd(0, 1, 2'b00, 8'h00, 2'b11, 8'd7, 0);
    run_cmd(1, 0, 2'b10, 8'd200, 2'b00, 8'h00, 3);
    run_cmd(0, 1, 2'b00, 8'h5a, 2'b00, 8'h00, 1);
    run_cmd(1, 0, 2'b01, 8'd255, 2'b00, 8'h00, 0);
    @(negedge clk);
    req0_valid = 1; req0_op = 2'b10; req0_arg = 8'd200;
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_run", o_state, 2);
    reset_n = 0;
    #1;
    chk("async_state", o_state, 0);
    chk("async_load", cnt_load, 1);
    chk("async_done", done_valid, 0);
    cur = 0; ptr = 0;
    @(negedge clk);
    chk("rst_no_done", done_valid, 0);
    reset_n = 1;
    run_cmd(1, 1, 2'b01, 8'd2, 2'b01, 8'd3, 0);
    for (int i = 0; i < 60; i++) begin
      logic [1:0] o0, o1;
      logic [7:0] a0, a1;
      o0 = 2'($urandom_range(0, 3));
      o1 = 2'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      a1 = 8'($urandom_range(0, 12));
      run_cmd(1'($urandom), 1'($urandom), o0, a0, o1, a1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cntr8_sched.md
# cntr8_sched

Command scheduler for the 8-bit loadable counter `cntr8`. It lets two independent requesters share one counter: each command is a LOAD, or an UP or DOWN run of N cycles. Commands are accepted with a valid/ready handshake and arbitrated round-robin. The block drives the counter's `load`/`inc`/`d_in` pins and observes its `d_out`. While no command is executing, it freezes the counter by reloading the counter's own output every cycle. It sits between the command sources and the `cntr8` instance, and reports completion with a one-cycle done strobe.

## Interface
Parameters: none; all widths are fixed.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: command valid from requester 0 / 1.
- `req0_op`, `req1_op` in 2: opcode. 00 = LOAD, 01 = UP, 10 = DOWN, 11 = reserved.
- `req0_arg`, `req1_arg` in 8: load value for LOAD; run length in cycles for UP/DOWN.
- `req0_ready`, `req1_ready` out 1: command accepted on this edge when valid and ready are both high.
- `abort` in 1: synchronous; terminates the current LOAD or RUN.
- `cnt_load` out 1: to `cntr8.load`.
- `cnt_inc` out 1: to `cntr8.inc`.
- `cnt_d_in` out 8: to `cntr8.d_in`.
- `cnt_d_out` in 8: from `cntr8.d_out`.
- `done_valid` out 1: one-cycle completion strobe.
- `done_id` out 1: requester that owned the finished command.
- `done_err` out 1: set with `done_valid` on a reserved opcode or an abort.
- `done_val` out 8: equals `cnt_d_out` while `done_valid` is high.
- `o_state` out 2: FSM state. IDLE = 00, LOAD = 01, RUN = 10, DONE = 11.

## Operation
**IDLE**
- Freeze the counter: `cnt_load` = 1, `cnt_d_in` = `cnt_d_out`, `cnt_inc` = 0.
- Grant one requester combinationally; `reqX_ready` is high only for the winner, and only in IDLE.
- If only one requester is valid, it wins.
- If both are valid, the winner is the requester named by the round-robin pointer. The pointer then moves to the other requester. A single-requester grant sets the pointer to the other requester.
- On accept, register the opcode, argument and requester id.

**Next state after accept**
- LOAD goes to the LOAD state.
- UP or DOWN with arg ≠ 0 goes to RUN with `remaining` = arg.
- UP or DOWN with arg = 0 goes to DONE; the counter is not stepped.
- Reserved opcode 11 goes to DONE with the error flag set.

**LOAD**
- Drive `cnt_load` = 1 and `cnt_d_in` = arg_q for exactly one cycle, then go to DONE.

**RUN**
- Drive `cnt_load` = 0 and `cnt_inc` = 1 for UP, 0 for DOWN.
- Decrement `remaining` each cycle (8-bit).
- When `remaining` == 1, go to DONE.
- Exactly arg counter steps occur. arg = 255 gives 255 steps; no wrap of `remaining`.

**DONE**
- Freeze the counter as in IDLE.
- Assert `done_valid`, `done_id` = owner and `done_err` = error flag, with `done_val` = `cnt_d_out`.
- Go to IDLE on the next edge. No command is accepted in DONE.

**Abort**
- `abort` high in LOAD or RUN: this edge is treated as the final edge of that state. The next state is DONE with `done_err` = 1.
- In RUN, the step in progress on that edge still completes, because `cnt_load` is still 0.
- In LOAD, the load on that edge still completes.
- Abort is ignored in IDLE and DONE.

**Reset**
- State = IDLE, pointer = requester 0, all registered fields = 0.
- Outputs: `cnt_load` = 1, `cnt_inc` = 0, `cnt_d_in` = `cnt_d_out`, `done_valid` / `done_id` / `done_err` = 0, `o_state` = 00, both ready signals follow the IDLE grant rule.
- Reset asserted mid-RUN or mid-LOAD drops to IDLE immediately. No done strobe is issued for the interrupted command.

## Timing
- Accept edge T0 → state transition at T0.
- LOAD command: counter loaded at edge T1, `done_valid` high during cycle T1–T2, back in IDLE at T2.
- UP/DOWN with arg = N: steps on edges T1..TN, `done_valid` high during the cycle after TN.
- Zero-length and reserved commands: `done_valid` in the cycle directly after T0.
- Back-to-back throughput: one command per (latency + 2) cycles. A new accept is possible in the first IDLE cycle after DONE.
- `done_val` reflects the counter value after the final step or load.
- `cnt_d_in` passthrough is combinational from `cnt_d_out` in IDLE and DONE. `cntr8` registers it, so no loop exists.
- Ready signals are combinational from the valid signals and the pointer, and only in IDLE. Requesters must hold op/arg stable while valid is high.

## Test plan
The bench uses a ±1-per-cycle stub counter model with reset value 0x00.

- Req0 LOAD 0x10 → `cnt_load` high for 1 cycle with `cnt_d_in` = 0x10; `done_valid` with `done_id` = 0 and `done_val` = 0x10; `cnt_d_out` stays 0x10 for 20 idle cycles.
- Req1 UP 5 after LOAD 0x10 → exactly 5 cycles with `cnt_load` = 0 and `cnt_inc` = 1; `done_val` = 0x15, `done_id` = 1, `done_err` = 0.
- Both requesters valid continuously, alternating DOWN 1 → grants alternate 0,1,0,1; each done decrements the value by 1; no requester is starved.
- UP 0 and reserved opcode 11 → `done_valid` one cycle after accept, counter unchanged; `done_err` = 0 for UP 0 and 1 for op 11.
- DOWN 200 with `abort` on the 3rd RUN cycle → 3 steps taken, `done_err` = 1, then IDLE with the counter frozen.
- `reset_n` pulsed low mid-RUN → `o_state` = 00 and `cnt_load` = 1 immediately with no clock edge; no `done_valid`; the pointer returns to req0.
